timer_tc: RTL and testbench

Memory-mapped countdown timer for the P7 CPU system. It sits on the data bus beside data memory, behind the system bridge, and drives one of the CPU's external interrupt inputs. Software programs it with word writes and reads back its registers. It raises a level interrupt when the count expires; the interrupt stays high until software writes the timer again.

---
 rtl/timer_tc.sv | 169 ++++++++++++++++
 tb/tb_timer_tc.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/timer_tc.sv
// Memory-mapped countdown timer with level interrupt for the P7 data bus.
// Optional prescaler in CTRL[11:8] is built when TIMER_PRESCALE_EN is defined.
module timer_tc #(
  parameter logic [31:0] BASE = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  // state | meaning
  // IDLE  | stopped, waiting for EN
  // LOAD  | copy PRESET into COUNT
  // CNT   | decrement COUNT on each tick
  // INT   | expiry seen; reload or stop depending on MODE
  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_e;

  state_e      state_q, state_d;
  logic        en_q, en_d;
  logic [1:0]  mode_q, mode_d;
  logic        im_q, im_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        pend_q, pend_d;
  logic        irq_q, irq_d;
  logic        hit;
  logic [1:0]  off;
  logic        tick;
  logic        unused_bits;

`ifdef TIMER_PRESCALE_EN
  logic [3:0]  psc_q, psc_d;
  logic [3:0]  psc_cnt_q, psc_cnt_d;
  assign tick = (psc_cnt_q == psc_q);
`else
  assign tick = 1'b1;
`endif

  assign hit = (addr[31:4] == BASE[31:4]);
  assign off = addr[3:2];
  assign unused_bits = ^{addr[1:0], wdata[31:4]};

  always_comb begin
    rdata = 32'd0;
    if (hit) begin
      case (off)
`ifdef TIMER_PRESCALE_EN
        2'd0: rdata = {20'd0, psc_q, 4'd0, im_q, mode_q, en_q};
`else
        2'd0: rdata = {28'd0, im_q, mode_q, en_q};
`endif
        2'd1: rdata = preset_q;
        2'd2: rdata = count_q;
        default: rdata = 32'd0;
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    en_d     = en_q;
    mode_d   = mode_q;
    im_d     = im_q;
    preset_d = preset_q;
    count_d  = count_q;
    pend_d   = pend_q;
    irq_d    = pend_q & im_q;
`ifdef TIMER_PRESCALE_EN
    psc_d     = psc_q;
    psc_cnt_d = psc_cnt_q;
`endif

    case (state_q)
      IDLE: if (en_q) state_d = LOAD;
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
`ifdef TIMER_PRESCALE_EN
        psc_cnt_d = 4'd0;
`endif
      end
      CNT: begin
        if (!en_q) begin
          state_d = IDLE;
        end else begin
`ifdef TIMER_PRESCALE_EN
          psc_cnt_d = tick ? 4'd0 : psc_cnt_q + 4'd1;
`endif
          if (tick) begin
            if (count_q > 32'd1) begin
              count_d = count_q - 32'd1;
            end else begin
              count_d = 32'd0;
              pend_d  = 1'b1;
              state_d = INT;
            end
          end
        end
      end
      INT: begin
        if (mode_q == 2'b01) begin
          state_d = LOAD;
        end else begin
          en_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Software writes restart the sequence and win over any FSM update above
    if (we && hit && (off == 2'd0 || off == 2'd1)) begin
      state_d = IDLE;
      pend_d  = 1'b0;
      count_d = count_q;
`ifdef TIMER_PRESCALE_EN
      psc_cnt_d = 4'd0;
`endif
      if (off == 2'd0) begin
        en_d   = wdata[0];
        mode_d = wdata[2:1];
        im_d   = wdata[3];
`ifdef TIMER_PRESCALE_EN
        psc_d  = wdata[11:8];
`endif
      end else begin
        en_d     = en_q;
        preset_d = wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      en_q     <= 1'b0;
      mode_q   <= 2'b00;
      im_q     <= 1'b0;
      preset_q <= 32'd0;
      count_q  <= 32'd0;
      pend_q   <= 1'b0;
      irq_q    <= 1'b0;
`ifdef TIMER_PRESCALE_EN
      psc_q     <= 4'd0;
      psc_cnt_q <= 4'd0;
`endif
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      im_q     <= im_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      irq_q    <= irq_d;
`ifdef TIMER_PRESCALE_EN
      psc_q     <= psc_d;
      psc_cnt_q <= psc_cnt_d;
`endif
    end
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_timer_tc.sv
// Directed bench for timer_tc: register decode, one-shot, auto-reload, masking, stop and reset.
module tb_timer_tc;

  localparam logic [31:0] A_CTRL = 32'h0000_7F00;
  localparam logic [31:0] A_PRE  = 32'h0000_7F04;
  localparam logic [31:0] A_CNT  = 32'h0000_7F08;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int errs;
  int checks;

  timer_tc dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .we   (we),
    .wdata(wdata),
    .rdata(rdata),
    .irq  (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Write lands on the next posedge; returns 1 time unit after it
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(posedge clk);
    #1;
    we    = 1'b0;
    addr  = 32'd0;
    wdata = 32'd0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  task automatic chk_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] v;
    rd(a, v);
    chk(tag, v, exp);
  endtask

  initial begin
    errs   = 0;
    checks = 0;
    reset  = 1'b1;
    addr   = 32'd0;
    we     = 1'b0;
    wdata  = 32'd0;
    step(2);
    @(negedge clk);
    reset = 1'b0;
    step(1);

    chk_rd("rst_ctrl", A_CTRL, 32'd0);
    chk_rd("rst_pre", A_PRE, 32'd0);
    chk_rd("rst_cnt", A_CNT, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);

    // Decode: aliasing of addr[1:0], unused offset, misses, read-only COUNT
    wr(A_PRE, 32'hDEAD_BEEF);
    chk_rd("pre_rw", A_PRE, 32'hDEAD_BEEF);
    chk_rd("pre_lowbits", 32'h0000_7F07, 32'hDEAD_BEEF);
    chk_rd("off_c", 32'h0000_7F0C, 32'd0);
    chk_rd("miss_rd", 32'h0000_7F14, 32'd0);
    wr(32'h0000_8F04, 32'h1234_5678);
    chk_rd("miss_wr", A_PRE, 32'hDEAD_BEEF);
    wr(A_CNT, 32'h0000_0055);
    chk_rd("cnt_ro", A_CNT, 32'd0);
    wr(A_CTRL, 32'hFFFF_FFFE);
`ifdef TIMER_PRESCALE_EN
    chk_rd("ctrl_mask", A_CTRL, 32'h0000_0F0E);
`else
    chk_rd("ctrl_mask", A_CTRL, 32'h0000_000E);
`endif
    wr(A_CTRL, 32'd0);

    // One-shot, PRESET=5
    wr(A_PRE, 32'd5);
    wr(A_CTRL, 32'h9);
    step(1);
    chk_rd("os_load", A_CNT, 32'd0);
    step(1);
    chk_rd("os_cnt5", A_CNT, 32'd5);
    for (int k = 1; k <= 5; k++) begin
      step(1);
      chk_rd($sformatf("os_cnt%0d", 5 - k), A_CNT, 32'(5 - k));
    end
    chk("os_irq_e7", {31'd0, irq}, 32'd0);
    step(1);
    chk("os_irq_e8", {31'd0, irq}, 32'd1);
    step(1);
    chk_rd("os_en_clr", A_CTRL, 32'h8);
    step(5);
    chk_rd("os_cnt_hold", A_CNT, 32'd0);
    chk("os_irq_hold", {31'd0, irq}, 32'd1);

    // Auto-reload, PRESET=3
    wr(A_PRE, 32'd3);
    wr(A_CTRL, 32'hB);
    step(5);
    chk_rd("ar_exp1", A_CNT, 32'd0);
    chk("ar_irq_e5", {31'd0, irq}, 32'd0);
    step(1);
    chk("ar_irq_e6", {31'd0, irq}, 32'd1);
    step(1);
    chk_rd("ar_reload", A_CNT, 32'd3);
    step(2);
    chk_rd("ar_cnt1", A_CNT, 32'd1);
    step(1);
    chk_rd("ar_exp2", A_CNT, 32'd0);
    chk("ar_pend", {31'd0, irq}, 32'd1);
    step(2);
    chk_rd("ar_reload2", A_CNT, 32'd3);
    wr(A_CTRL, 32'h0);
    step(1);
    chk("ar_irq_drop", {31'd0, irq}, 32'd0);
    chk_rd("ar_freeze", A_CNT, 32'd3);
    step(3);
    chk_rd("ar_freeze2", A_CNT, 32'd3);

    // Masked expiry, then unmasking write clears pending
    wr(A_PRE, 32'd2);
    wr(A_CTRL, 32'h1);
    step(6);
    chk_rd("msk_cnt", A_CNT, 32'd0);
    chk("msk_irq", {31'd0, irq}, 32'd0);
    chk_rd("msk_en_clr", A_CTRL, 32'd0);
    wr(A_CTRL, 32'h8);
    step(2);
    chk("msk_unmask", {31'd0, irq}, 32'd0);

    // Stop mid-count at COUNT=7, then restart reloads PRESET
    wr(A_PRE, 32'd10);
    wr(A_CTRL, 32'h1);
    step(5);
    chk_rd("stop_pre7", A_CNT, 32'd7);
    wr(A_CTRL, 32'h0);
    chk_rd("stop_hold", A_CNT, 32'd7);
    step(3);
    chk_rd("stop_hold2", A_CNT, 32'd7);
    wr(A_CTRL, 32'h1);
    step(1);
    chk_rd("restart_load", A_CNT, 32'd7);
    step(1);
    chk_rd("restart_cnt", A_CNT, 32'd10);

    // Reset while counting with irq high
    wr(A_PRE, 32'd3);
    wr(A_CTRL, 32'hB);
    step(8);
    chk("prerst_irq", {31'd0, irq}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    step(1);
    chk("mrst_irq", {31'd0, irq}, 32'd0);
    chk_rd("mrst_cnt", A_CNT, 32'd0);
    chk_rd("mrst_ctrl", A_CTRL, 32'd0);
    chk_rd("mrst_pre", A_PRE, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step(3);
    chk_rd("mrst_idle", A_CNT, 32'd0);

`ifdef TIMER_PRESCALE_EN
    // PSC=3: one tick every 4 cycles
    wr(A_PRE, 32'd2);
    wr(A_CTRL, 32'h309);
    step(2);
    chk_rd("psc_e2", A_CNT, 32'd2);
    step(3);
    chk_rd("psc_e5", A_CNT, 32'd2);
    step(1);
    chk_rd("psc_e6", A_CNT, 32'd1);
    step(3);
    chk_rd("psc_e9", A_CNT, 32'd1);
    step(1);
    chk_rd("psc_e10", A_CNT, 32'd0);
    chk("psc_irq_e10", {31'd0, irq}, 32'd0);
    step(1);
    chk("psc_irq_e11", {31'd0, irq}, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
